// File: rtl/lzrw1_stream_decompressor_pkg.sv
// ----------------------------------------------------------------------------
// decompressor_types
//   Shared types and default sizing for the LZRW1 stream decompressor.
//   - HISTORY_SIZE_DEF / OFF_WIDTH_DEF / LEN_WIDTH_DEF : default geometry
//   - err_code_e     : sticky illegal-token classification
//   - decomp_state_e : control FSM states
// ----------------------------------------------------------------------------
package decompressor_types;

    localparam int HISTORY_SIZE_DEF = 4096;
    localparam int OFF_WIDTH_DEF    = 12;
    localparam int LEN_WIDTH_DEF    = 4;

    typedef enum logic [1:0] {
        ERR_NONE        = 2'd0,
        ERR_ZERO_LEN    = 2'd1,
        ERR_ZERO_OFF    = 2'd2,
        ERR_OFF_GT_FILL = 2'd3
    } err_code_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LIT  = 2'd1,
        COPY = 2'd2
    } decomp_state_e;

endpackage

// File: rtl/lzrw1_stream_decompressor_history_ram.sv
// ----------------------------------------------------------------------------
// lzrw1_history_ram
//   Simple dual-port byte RAM holding the decompression history window.
//   One write port and one synchronous read port (1-cycle read latency).
//   A read and a write to the same address in the same cycle returns the
//   OLD contents; the caller is responsible for forwarding.
// Ports:
//   clock    : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write byte
//   i_raddr  : read address (sampled every cycle)
//   o_rdata  : read byte, valid the cycle after i_raddr
// ----------------------------------------------------------------------------
module lzrw1_history_ram
    import decompressor_types::*;
#(
    parameter int DEPTH = HISTORY_SIZE_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // Single process with non-blocking writes gives read-old-data behaviour.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lzrw1_stream_decompressor.sv
// ----------------------------------------------------------------------------
// lzrw1_stream_decompressor
//   LZRW1 token-to-byte decompressor with valid/ready on both sides.
//   One token (literal byte or {length, offset} copy) is accepted per input
//   handshake while idle; one decompressed byte leaves per output handshake.
//   Copies run at one byte per cycle, including overlapping copies, using a
//   one-entry forward register around the read-old-data history RAM.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   in_valid / in_ready     : token handshake
//   in_is_copy              : 1 = copy token, 0 = literal
//   in_first                : token starts a new block (history fill cleared)
//   in_data                 : copy {length, offset}; literal byte in [7:0]
//   out_valid / out_ready   : byte handshake
//   out_data                : decompressed byte
//   busy                    : state != IDLE
//   error, error_code       : sticky flag and first illegal-token code
// ----------------------------------------------------------------------------
module lzrw1_stream_decompressor
    import decompressor_types::*;
#(
    parameter int HISTORY_SIZE = HISTORY_SIZE_DEF,
    parameter int OFF_WIDTH    = OFF_WIDTH_DEF,
    parameter int LEN_WIDTH    = LEN_WIDTH_DEF
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_is_copy,
    input  logic                           in_first,
    input  logic [LEN_WIDTH+OFF_WIDTH-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [7:0]                     out_data,
    output logic                           busy,
    output logic                           error,
    output logic [1:0]                     error_code
);

    localparam int AW = $clog2(HISTORY_SIZE);
    localparam int FW = AW + 1;
    localparam int DW = LEN_WIDTH + OFF_WIDTH;

    decomp_state_e          r_state;
    decomp_state_e          w_state_nxt;
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW-1:0]          w_rd_addr;
    logic [FW-1:0]          r_fill;
    logic [FW-1:0]          w_fill_base;
    logic [LEN_WIDTH-1:0]   r_rem;
    logic [7:0]             r_lit;
    logic [7:0]             r_fwd_byte;
    logic                   r_fwd_hit;
    logic                   r_err;
    err_code_e              r_err_code;
    err_code_e              w_chk_code;
    logic [7:0]             w_ram_rdata;
    logic [7:0]             w_out_byte;
    logic                   w_accept;
    logic                   w_out_hs;
    logic [LEN_WIDTH-1:0]   w_len;
    logic [OFF_WIDTH-1:0]   w_off;

    assign w_len       = in_data[DW-1:OFF_WIDTH];
    assign w_off       = in_data[OFF_WIDTH-1:0];
    assign in_ready    = (r_state == IDLE) && !reset;
    assign out_valid   = (r_state != IDLE);
    assign busy        = (r_state != IDLE);
    assign out_data    = w_out_byte;
    assign error       = r_err;
    assign error_code  = r_err_code;
    assign w_accept    = in_valid && in_ready;
    assign w_out_hs    = out_valid && out_ready;

    // A block-start token sees an empty history for its own legality check.
    assign w_fill_base = in_first ? '0 : r_fill;

    always_comb begin
        w_chk_code = ERR_NONE;
        if (w_len == '0) begin
            w_chk_code = ERR_ZERO_LEN;
        end else if (w_off == '0) begin
            w_chk_code = ERR_ZERO_OFF;
        end else if (FW'(w_off) > w_fill_base) begin
            w_chk_code = ERR_OFF_GT_FILL;
        end
    end

    // Read address: computed from the token while idle so the first copy byte
    // is available the cycle after acceptance; held while stalled.
    always_comb begin
        w_rd_addr = r_rd_ptr;
        if (r_state == IDLE) begin
            w_rd_addr = r_wr_ptr - AW'(w_off);
        end else if ((r_state == COPY) && w_out_hs) begin
            w_rd_addr = r_rd_ptr + AW'(1);
        end
    end

    always_comb begin
        w_out_byte = 8'h00;
        case (r_state)
            LIT:     w_out_byte = r_lit;
            COPY:    w_out_byte = r_fwd_hit ? r_fwd_byte : w_ram_rdata;
            default: w_out_byte = 8'h00;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!in_is_copy) begin
                        w_state_nxt = LIT;
                    end else if (w_chk_code == ERR_NONE) begin
                        w_state_nxt = COPY;
                    end
                end
            end
            LIT: begin
                if (w_out_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            COPY: begin
                if (w_out_hs && (r_rem == LEN_WIDTH'(1))) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    lzrw1_history_ram #(
        .DEPTH (HISTORY_SIZE),
        .AW    (AW)
    ) u_hist (
        .clock   (clock),
        .i_we    (w_out_hs),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_out_byte),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ram_rdata)
    );

    // ---- control registers ----
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wr_ptr   <= '0;
            r_fill     <= '0;
            r_rem      <= '0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_fwd_hit  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            // RAM returns old data when the byte being read is written this
            // very cycle; remember that so the next cycle uses the new byte.
            r_fwd_hit <= w_out_hs && (r_wr_ptr == w_rd_addr);
            if (w_accept && in_first) begin
                r_fill <= '0;
            end
            if (w_accept && in_is_copy) begin
                r_rem <= w_len;
                if ((w_chk_code != ERR_NONE) && !r_err) begin
                    r_err      <= 1'b1;
                    r_err_code <= w_chk_code;
                end
            end
            if (w_out_hs) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (r_fill != FW'(HISTORY_SIZE)) begin
                    r_fill <= r_fill + FW'(1);
                end
                if (r_state == COPY) begin
                    r_rem <= r_rem - LEN_WIDTH'(1);
                end
            end
        end
    end

    // ---- data registers ----
    always_ff @(posedge clock) begin
        r_rd_ptr   <= w_rd_addr;
        r_fwd_byte <= w_out_byte;
        if (w_accept && !in_is_copy) begin
            r_lit <= in_data[7:0];
        end
    end

endmodule

// File: tb/tb_lzrw1_stream_decompressor.sv
module tb_lzrw1_stream_decompressor;

    localparam int HS  = 16;
    localparam int OFW = 4;
    localparam int LNW = 4;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             in_is_copy;
    logic             in_first;
    logic [LNW+OFW-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             busy;
    logic             error;
    logic [1:0]       error_code;

    lzrw1_stream_decompressor #(
        .HISTORY_SIZE (HS),
        .OFF_WIDTH    (OFW),
        .LEN_WIDTH    (LNW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_is_copy (in_is_copy),
        .in_first   (in_first),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .error      (error),
        .error_code (error_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: the whole emitted byte stream plus block fill count.
    byte unsigned hist[$];
    int unsigned  expq[$];
    int           mfill;
    bit           merr;
    int           mcode;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mfill = 0;
        merr  = 0;
        mcode = 0;
        expq.delete();
    endtask

    task automatic model_tok(input bit cp, input bit first, input int d);
        int len, off, code;
        if (first) mfill = 0;
        if (!cp) begin
            hist.push_back(byte'(d & 255));
            expq.push_back(d & 255);
            if (mfill < HS) mfill++;
        end else begin
            len  = (d >> OFW) & 15;
            off  = d & 15;
            code = (len == 0) ? 1 : (off == 0) ? 2 : (off > mfill) ? 3 : 0;
            if (code != 0) begin
                if (!merr) begin
                    merr  = 1;
                    mcode = code;
                end
            end else begin
                for (int k = 0; k < len; k++) begin
                    byte unsigned b;
                    b = hist[hist.size() - off];
                    hist.push_back(b);
                    expq.push_back(b);
                    if (mfill < HS) mfill++;
                end
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input bit cp, input bit first, input int d);
        chk("in_ready_idle", in_ready, 1);
        in_valid   = 1'b1;
        in_is_copy = cp;
        in_first   = first;
        in_data    = d[7:0];
        @(negedge clock);
        in_valid   = 1'b0;
        in_is_copy = 1'b0;
        in_first   = 1'b0;
        model_tok(cp, first, d);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random
    task automatic collect(input int mode);
        int          k = 0;
        int          stalls = 0;
        bit          rdy;
        logic [7:0]  prev;
        while (expq.size() > 0) begin
            rdy = 1'b1;
            if (mode == 1) rdy = ((k % 4) == 0) || ((k % 4) == 3);
            else if (mode == 2) rdy = ($urandom_range(0, 2) != 0);
            if (stalls >= 8) rdy = 1'b1;
            k++;
            out_ready = rdy;
            chk("out_valid_busy", out_valid, 1);
            if (rdy) begin
                chk("out_data", out_data, expq.pop_front());
                stalls = 0;
                @(negedge clock);
            end else begin
                prev = out_data;
                stalls++;
                @(negedge clock);
                chk("stall_stable", out_data, prev);
            end
        end
        chk("out_valid_done", out_valid, 0);
        chk("busy_done", busy, 0);
        chk("error", error, merr);
        chk("error_code", error_code, mcode);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_code", error_code, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_in_ready", in_ready, 1);
        model_reset();
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_is_copy = 1'b0;
        in_first   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        model_reset();
        do_reset();

        // Literals then a back-reference copy
        send(0, 1, 8'h41); collect(0);
        send(0, 0, 8'h42); collect(0);
        send(0, 0, 8'h43); collect(0);
        send(1, 0, 8'h33); collect(0);

        // Offset 1 replication through the forward path
        send(0, 1, 8'h78); collect(0);
        send(1, 0, 8'h51); collect(0);

        // Same as the first scenario under output backpressure
        send(0, 1, 8'h41); collect(1);
        send(0, 0, 8'h42); collect(1);
        send(0, 0, 8'h43); collect(1);
        send(1, 0, 8'h33); collect(1);

        // Fill from address 0 so the copy's writes wrap 15 -> 0
        do_reset();
        for (int i = 0; i < 14; i++) begin
            send(0, (i == 0), i);
            collect(0);
        end
        send(1, 0, 8'h43); collect(0);

        // Offset beyond fill, then sticky code on a block-start copy
        send(0, 1, 8'h61); collect(0);
        send(0, 0, 8'h62); collect(0);
        send(1, 0, 8'h25); collect(0);
        chk("err_set", error, 1);
        chk("err_code3", error_code, 3);
        send(0, 0, 8'h63); collect(0);
        send(1, 1, 8'h21); collect(0);
        chk("err_code_sticky", error_code, 3);

        // Reset in the middle of a copy
        send(0, 1, 8'h10); collect(0);
        send(0, 0, 8'h20); collect(0);
        send(1, 0, 8'h82);
        out_ready = 1'b1;
        chk("mid_b1_valid", out_valid, 1);
        chk("mid_b1_data", out_data, 8'h10);
        @(negedge clock);
        chk("mid_b2_valid", out_valid, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        reset = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_error", error, 0);
        model_reset();

        // Randomized token stream against the reference model
        for (int n = 0; n < 300; n++) begin
            int r, len, off, maxo;
            bit first;
            r     = $urandom_range(0, 19);
            first = (r == 0) || (n == 0);
            if (r < 9) begin
                send(0, first, $urandom_range(0, 255));
            end else if (r == 19) begin
                send(1, first, $urandom_range(0, 255));
            end else begin
                maxo = (mfill > 15) ? 15 : mfill;
                len  = $urandom_range(1, 15);
                off  = (maxo > 0) ? $urandom_range(1, maxo) : 1;
                send(1, (mfill > 0) ? 1'b0 : first, (len << 4) | off);
            end
            collect(2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
